// File: rtl/dmem_write_tracer.sv
// -----------------------------------------------------------------------------
// dmem_write_tracer
//
// A passive monitor that sits downstream of system_debug. It records every
// data-memory write into a first-word-fall-through trace FIFO and counts
// retired instructions. When the halt instruction (jump-to-self) appears, it
// freezes capture and counting. The trace is drained through a valid/ready
// port, so consumers do not need to snoop the register file hierarchically.
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   clear              synchronous return to reset state (FIFO emptied)
//   instruction        current instruction word
//   dmem_we            data-memory write enable
//   alu_out            data-memory address; low ADDR_BITS are recorded
//   dmem_wd            data-memory write data
//   out_valid          head trace entry available
//   out_ready          consumer accepts the head entry
//   out_addr/data/seq  head entry fields (zero while out_valid = 0)
//   instr_count        retired-instruction counter, saturating
//   halted             halt instruction has been seen
//   overflow           sticky: at least one write was dropped on a full FIFO
//   drop_count         number of dropped writes, saturating
// -----------------------------------------------------------------------------
module dmem_write_tracer #(
  parameter int          DEPTH      = 16,  // power of two, >= 2
  parameter int          ADDR_BITS  = 10,  // < 32
  parameter logic [31:0] HALT_INSTR = 32'h0800001F
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [31:0]          instruction,
  input  logic                 dmem_we,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          dmem_wd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [31:0]          out_data,
  output logic [15:0]          out_seq,
  output logic [15:0]          instr_count,
  output logic                 halted,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          data;
    logic [15:0]          seq;
  } entry_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      instr_count_q, instr_count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  entry_t mem_q [DEPTH];
  entry_t head;
  entry_t new_entry;

  logic is_halt, in_run, empty, full, pop, capture, push, drop, mem_we;

  // The upper address bits are intentionally not recorded.
  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_out[31:ADDR_BITS];

  // NOTE: every signal assigned here receives a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_halt   = (instruction == HALT_INSTR);
    in_run    = (state_q == S_RUN);
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = !empty && out_ready;
    capture   = in_run && dmem_we && !is_halt;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push      = capture && (!full || pop);
    drop      = capture && full && !pop;
    new_entry = '{addr: alu_out[ADDR_BITS-1:0], data: dmem_wd, seq: instr_count_q};

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    instr_count_d = instr_count_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    mem_we        = 1'b0;

    if (clear) begin
      state_d       = S_RUN;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      instr_count_d = '0;
      overflow_d    = 1'b0;
      drop_count_d  = '0;
    end else begin
      if (in_run && is_halt) state_d = S_HALTED;

      if (in_run && !is_halt && instr_count_q != 16'hFFFF)
        instr_count_d = instr_count_q + 16'd1;

      mem_we = push;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_count_q <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_count_q <= instr_count_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // NOTE: the storage array is not reset. Emptiness is carried by count_q, and the outputs are masked while empty, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_ptr_q] <= new_entry;
  end

  // First-word-fall-through read. The outputs are driven only from registers,
  // and they are forced to zero when empty so that they never show X.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = !empty;
    out_addr  = empty ? '0 : head.addr;
    out_data  = empty ? '0 : head.data;
    out_seq   = empty ? '0 : head.seq;
  end

  assign instr_count = instr_count_q;
  assign halted      = (state_q == S_HALTED);
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_dmem_write_tracer.sv
// -----------------------------------------------------------------------------
// tb_dmem_write_tracer
//
// Directed scenarios followed by a randomized phase. The DUT is compared
// every cycle against a queue-based reference model of the trace port,
// counters and flags.
// -----------------------------------------------------------------------------
module tb_dmem_write_tracer;

  localparam int          DEPTH = 16;
  localparam int          AB    = 10;
  localparam logic [31:0] HALT  = 32'h0800001F;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [31:0]   instruction = 32'h0;
  logic          dmem_we = 1'b0;
  logic [31:0]   alu_out = 32'h0;
  logic [31:0]   dmem_wd = 32'h0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [AB-1:0] out_addr;
  logic [31:0]   out_data;
  logic [15:0]   out_seq;
  logic [15:0]   instr_count;
  logic          halted;
  logic          overflow;
  logic [7:0]    drop_count;

  dmem_write_tracer #(.DEPTH(DEPTH), .ADDR_BITS(AB), .HALT_INSTR(HALT)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .instruction (instruction),
    .dmem_we     (dmem_we),
    .alu_out     (alu_out),
    .dmem_wd     (dmem_wd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_seq     (out_seq),
    .instr_count (instr_count),
    .halted      (halted),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  // Reference model
  typedef struct {
    logic [AB-1:0] addr;
    logic [31:0]   data;
    logic [15:0]   seq;
  } ent_t;

  ent_t  q[$];
  int    m_count;
  bit    m_halted;
  bit    m_ovf;
  int    m_drops;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_count  = 0;
    m_halted = 0;
    m_ovf    = 0;
    m_drops  = 0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] instr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic rdy, input logic clr);
    bit pop;
    if (clr) begin
      model_clear();
    end else begin
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (!m_halted) begin
        if (instr == HALT) begin
          m_halted = 1;
        end else begin
          if (we) begin
            if (q.size() < DEPTH) q.push_back('{addr[AB-1:0], wd, 16'(m_count)});
            else begin
              m_ovf = 1;
              if (m_drops < 255) m_drops++;
            end
          end
          if (m_count < 65535) m_count++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_addr", 64'(out_addr), 64'(q[0].addr));
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_seq",  64'(out_seq),  64'(q[0].seq));
    end else begin
      check("out_known", 64'($isunknown({out_addr, out_data, out_seq})), 64'(0));
    end
    check("instr_count", 64'(instr_count), 64'(m_count));
    check("halted",      64'(halted),      64'(m_halted));
    check("overflow",    64'(overflow),    64'(m_ovf));
    check("drop_count",  64'(drop_count),  64'(m_drops));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if (r == HALT) r = r ^ 32'h1;
    return r;
  endfunction

  // Drives one cycle's inputs, advances one edge, then compares.
  task automatic step(input logic we, input logic [31:0] instr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic rdy, input logic clr);
    dmem_we     = we;
    instruction = instr;
    alu_out     = addr;
    dmem_wd     = wd;
    out_ready   = rdy;
    clear       = clr;
    @(posedge clock);
    model_edge(we, instr, addr, wd, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, rand_instr(), $urandom, $urandom, rdy, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
    step(1'b1, rand_instr(), addr, wd, rdy, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b1);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    compare_all();
    check("reset_valid", 64'(out_valid), 64'(0));

    // Three writes on cycles 2, 5 and 6 with the consumer always ready.
    idle(1'b1);
    idle(1'b1);
    wr(32'h1FC, 32'h4, 1'b1);
    check("t1_seq0", 64'(out_seq), 64'(2));
    idle(1'b1);
    idle(1'b1);
    wr(32'h1F8, 32'hC, 1'b1);
    check("t1_seq1", 64'(out_seq), 64'(5));
    wr(32'h1F4, 32'h3, 1'b1);
    check("t1_seq2", 64'(out_seq), 64'(6));
    idle(1'b1);
    check("t1_drained", 64'(out_valid), 64'(0));

    // Twenty writes against a stalled consumer; the last four are dropped.
    do_clear();
    for (int i = 1; i <= 20; i++) wr($urandom, 32'(i), 1'b0);
    check("t2_overflow", 64'(overflow), 64'(1));
    check("t2_drops", 64'(drop_count), 64'(4));
    for (int i = 1; i <= 16; i++) begin
      check("t2_order", 64'(out_data), 64'(i));
      idle(1'b1);
    end
    check("t2_empty", 64'(out_valid), 64'(0));

    // A full FIFO with a simultaneous push and pop drops nothing.
    do_clear();
    for (int i = 1; i <= 16; i++) wr($urandom, 32'(i), 1'b0);
    check("t3_head", 64'(out_data), 64'(1));
    wr(32'h55, 32'hAA, 1'b1);
    check("t3_drops", 64'(drop_count), 64'(0));
    check("t3_newhead", 64'(out_data), 64'(2));
    for (int i = 0; i < 15; i++) idle(1'b1);
    check("t3_tail", 64'(out_data), 64'hAA);

    // Halt after 30 retired instructions; later writes are ignored but the FIFO drains.
    do_clear();
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, HALT, 32'h10, 32'hDEAD, 1'b0, 1'b0);
    check("t4_halted", 64'(halted), 64'(1));
    check("t4_count", 64'(instr_count), 64'(30));
    for (int i = 0; i < 4; i++) wr($urandom, $urandom, 1'b0);
    for (int i = 0; i < 18; i++) wr($urandom, $urandom, 1'b1);
    check("t4_count_hold", 64'(instr_count), 64'(30));

    // Clear while halted with three entries pending.
    do_clear();
    for (int i = 0; i < 3; i++) wr($urandom, $urandom, 1'b0);
    step(1'b0, HALT, 0, 0, 1'b0, 1'b0);
    do_clear();
    check("t5_valid", 64'(out_valid), 64'(0));
    check("t5_halted", 64'(halted), 64'(0));
    check("t5_count", 64'(instr_count), 64'(0));
    idle(1'b0);
    idle(1'b0);
    check("t5_resume", 64'(instr_count), 64'(2));

    // The drop counter saturates.
    do_clear();
    for (int i = 0; i < 16 + 260; i++) wr($urandom, $urandom, 1'b0);
    check("t6_drop_sat", 64'(drop_count), 64'hFF);

    // An asynchronous reset in mid-cycle with five entries pending.
    do_clear();
    for (int i = 0; i < 5; i++) wr($urandom, $urandom, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("t7_valid", 64'(out_valid), 64'(0));
    check("t7_count", 64'(instr_count), 64'(0));
    check("t7_drops", 64'(drop_count), 64'(0));
    model_clear();
    @(posedge clock);
    #1 reset = 1'b0;
    compare_all();

    // Randomized traffic with occasional halts and clears.
    for (int blk = 0; blk < 12; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 50; i++) begin
        step(1'($urandom_range(0, 2) != 0),
             ($urandom_range(0, 59) == 0) ? HALT : rand_instr(),
             $urandom, $urandom,
             1'($urandom_range(0, 99) < rdy_pct),
             1'($urandom_range(0, 69) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
